// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter. It sends a start bit, 8 data bits LSB first,
// an optional parity bit and one stop bit. Each bit lasts a runtime-selectable
// number of clock cycles. All frame settings are captured when the byte is
// accepted, so changing the inputs while a frame is being sent has no effect.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | start bit (low) for one bit period
// DATA   | data bits 0..7, LSB first
// PARITY | parity bit, only when enabled at accept
// STOP   | stop bit (high) for one bit period, then back to IDLE

module uart_tx (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        parity_bit_i,
    input  logic        parity_even_i,
    input  logic [15:0] clock_divider_i,
    output logic        serial_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      state;
    logic [7:0]  shift;
    logic        par_en;
    logic        par_val;
    logic [15:0] bit_len;    // bit period minus one, as latched at accept
    logic [15:0] div_cnt;    // cycles left in the current bit, counting down to 0
    logic [2:0]  bit_idx;
    logic [15:0] len_in;
    logic        bit_done;

    // A divider of 0 behaves like 1. The period is stored minus one so that a
    // 16-bit down-counter covers 65535 cycles without wrapping.
    always_comb begin
        len_in = 16'd0;
        if (clock_divider_i != 16'd0)
            len_in = clock_divider_i - 16'd1;
    end

    assign bit_done = (div_cnt == 16'd0);

    // Frame sequencer. serial_o and ready_o are registered here. Reset is
    // checked first, so it aborts a frame and also wins over an accept.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state    <= IDLE;
            serial_o <= 1'b1;
            ready_o  <= 1'b1;
            shift    <= 8'd0;
            par_en   <= 1'b0;
            par_val  <= 1'b0;
            bit_len  <= 16'd0;
            div_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    serial_o <= 1'b1;
                    ready_o  <= 1'b1;
                    if (valid_i) begin
                        state    <= START;
                        serial_o <= 1'b0;
                        ready_o  <= 1'b0;
                        shift    <= data_i;
                        par_en   <= parity_bit_i;
                        par_val  <= parity_even_i ? (^data_i) : ~(^data_i);
                        bit_len  <= len_in;
                        div_cnt  <= len_in;
                        bit_idx  <= 3'd0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state    <= DATA;
                        serial_o <= shift[0];
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= 3'd0;
                        div_cnt  <= bit_len;
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        div_cnt <= bit_len;
                        if (bit_idx == 3'd7) begin
                            if (par_en) begin
                                state    <= PARITY;
                                serial_o <= par_val;
                            end else begin
                                state    <= STOP;
                                serial_o <= 1'b1;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            serial_o <= shift[0];
                            shift    <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state    <= STOP;
                        serial_o <= 1'b1;
                        div_cnt  <= bit_len;
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                STOP: begin
                    serial_o <= 1'b1;
                    if (bit_done) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    serial_o <= 1'b1;
                    ready_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: none; all configuration arrives through runtime ports.
REQ-002 clock_i  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_i  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 data_i  input  8  byte to transmit.
REQ-005 valid_i  input  1  data_i holds a byte to send; sampled only when ready_o=1.
REQ-006 ready_o  output  1  1 = idle and able to accept a byte; 0 = frame in progress.
REQ-007 parity_bit_i  input  1  1 = insert a parity bit after data bit 7.
REQ-008 parity_even_i  input  1  1 = even parity, 0 = odd parity; ignored when parity_bit_i=0.
REQ-009 clock_divider_i  input  16  bit period in clock_i cycles; 0 is treated as 1.
REQ-010 serial_o  output  1  serial line; idles high.

Function
REQ-011 Accept: a byte is accepted on any rising edge where ready_o=1, valid_i=1 and reset_i=1.
REQ-012 On accept, data_i, parity_bit_i, parity_even_i and clock_divider_i are latched; input changes during the frame have no effect.
REQ-013 States: IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE: serial_o=1 and ready_o=1; on accept go to START.
REQ-015 START: serial_o=0 for N cycles (N = latched divider, min 1), then go to DATA.
REQ-016 DATA: drive the 8 data bits LSB first, each for N cycles; after bit 7 go to PARITY if parity is enabled, else to STOP.
REQ-017 PARITY: drive the parity bit for N cycles, then go to STOP.
REQ-018 Parity value: even = XOR of the 8 data bits; odd = inverse of that XOR.
REQ-019 STOP: serial_o=1 for N cycles, then go to IDLE.
REQ-020 Timing: the first start-bit cycle on serial_o is the cycle immediately after the accept edge.
REQ-021 ready_o is low from the cycle after accept for exactly 10*N cycles (11*N with parity).
REQ-022 serial_o is registered, with no combinational path from any input.
REQ-023 Back-to-back: valid_i=1 in the first cycle ready_o is high yields a new start bit on the next cycle, with no extra idle gap.
REQ-024 valid_i while ready_o=0 is ignored; no byte is queued.
REQ-025 The bit counter and the divider counter shall be wide enough for N=65535 without wrap-around error.
REQ-026 N=1: each bit lasts exactly one cycle; the frame takes 10 cycles (11 with parity).

Reset
REQ-027 When reset_i=0 at a rising edge, then on the next cycle: state=IDLE, serial_o=1, ready_o=1, all counters cleared.
REQ-028 Reset during a frame aborts it immediately; the partial frame is not resumed.
REQ-029 An accept in the same cycle as reset is discarded; reset takes priority.

Verification
REQ-030 Basic frame: divider=4, no parity, send 8'h55 -> serial_o = 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit held 4 cycles; ready_o low for 40 cycles.
REQ-031 Parity: divider=4; send 8'hA7 with even parity -> parity bit 1; send 8'h03 with odd parity -> parity bit 1; ready_o low for 44 cycles per frame.
REQ-032 Back-to-back: valid_i held high with 8'h0F then 8'hF0 -> the second start bit follows the first stop bit with no gap; a valid_i pulse mid-frame is ignored.
REQ-033 Reset mid-frame: assert reset_i=0 during data bit 3 -> serial_o=1 and ready_o=1 on the next cycle; a new 8'h55 frame after release is correct.
REQ-034 Edge divider and mid-frame change: divider=0 and divider=1 -> 1-cycle bits, 10-cycle frame; change clock_divider_i from 4 to 8 mid-frame -> current frame keeps 4-cycle bits.
REQ-035 Loopback: connect serial_o to UartRx (divider=4) and send 8'h55 -> UartRx ready_o rises and its data_o=8'h55.
